// File: rtl/sect409k1_pt_mul_host.sv
// Word-serial host front end for the sect409k1 point multiplier: packs a 409-bit
// scalar from W-bit words, runs one start/done handshake and streams x then y back out.
module sect409k1_pt_mul_host #(
  parameter int W  = 32,
  parameter int NW = 13
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         busy,
  output logic         err,
  output logic         pm_clr,
  output logic         pm_start,
  output logic [408:0] pm_d,
  input  logic         pm_done,
  input  logic [408:0] pm_x,
  input  logic [408:0] pm_y
);

  localparam int OPW = 409;
  localparam int CW  = $clog2(2 * NW);

  typedef enum logic [2:0] {
    S_LOAD   = 3'd0,
    S_START  = 3'd1,
    S_WAIT   = 3'd2,
    S_CAPT   = 3'd3,
    S_UNLOAD = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   wcnt_q, rcnt_q;
  logic            live_q;
  logic            err_q;
  logic            done_p1;
  logic [OPW-1:0]  scalar_q;
  logic [OPW-1:0]  x_q, y_q;
  logic            in_acc, out_acc, last_in, last_out, done_rise;
  logic [W-1:0]    word_sel;

  // Word idx of an operand zero-extended to NW*W bits; bits past the operand read as 0.
  function automatic logic [W-1:0] op_word(input logic [OPW-1:0] v, input int idx);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++)
      if (idx * W + i < OPW) w[i] = v[idx * W + i];
    return w;
  endfunction

  assign in_ready  = (state_q == S_LOAD) && live_q;
  assign out_valid = (state_q == S_UNLOAD);
  assign busy      = (state_q != S_LOAD);
  assign err       = err_q;
  assign pm_clr    = clr;
  assign pm_start  = (state_q == S_START);
  assign pm_d      = scalar_q;

  assign in_acc    = in_valid && in_ready && !clr;
  assign out_acc   = out_valid && out_ready;
  assign last_in   = (wcnt_q == CW'(NW - 1));
  assign last_out  = (rcnt_q == CW'(2 * NW - 1));
  // done_p1 lags pm_done by one cycle, so a level already high at START is not an edge.
  assign done_rise = pm_done && !done_p1;

  always_comb begin
    word_sel = '0;
    if (rcnt_q < CW'(NW)) word_sel = op_word(x_q, int'(rcnt_q));
    else                  word_sel = op_word(y_q, int'(rcnt_q) - NW);
    out_data = out_valid ? word_sel : '0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:   if (in_acc && last_in) state_d = S_START;
      S_START:  state_d = S_WAIT;
      S_WAIT:   if (done_rise) state_d = S_CAPT;
      S_CAPT:   state_d = S_UNLOAD;
      S_UNLOAD: if (out_acc && last_out) state_d = S_LOAD;
      default:  state_d = S_LOAD;
    endcase
    if (clr) state_d = S_LOAD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_LOAD;
      wcnt_q   <= '0;
      rcnt_q   <= '0;
      live_q   <= 1'b0;
      err_q    <= 1'b0;
      done_p1  <= 1'b0;
      scalar_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      done_p1 <= pm_done;
      if (clr) begin
        wcnt_q   <= '0;
        rcnt_q   <= '0;
        err_q    <= 1'b0;
        scalar_q <= '0;
        x_q      <= '0;
        y_q      <= '0;
      end else begin
        if (in_valid && !in_ready) err_q <= 1'b1;
        // Input stage: word wcnt lands in its slot; bits above 408 of the top word fall away.
        if (in_acc) begin
          wcnt_q <= last_in ? '0 : wcnt_q + CW'(1);
          for (int b = 0; b < OPW; b++)
            if (wcnt_q == CW'(b / W)) scalar_q[b] <= in_data[b % W];
        end
        // Capture stage: one cycle after the done edge, results are stable to register.
        if (state_q == S_CAPT) begin
          x_q <= pm_x;
          y_q <= pm_y;
        end
        // Output stage: rcnt only moves on acceptance, so stalled words hold steady.
        if (out_acc) rcnt_q <= last_out ? '0 : rcnt_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sect409k1_pt_mul_host.sv
// Directed bench for sect409k1_pt_mul_host with a behavioural core stub
// (x = d, y = ~d over 409 bits, done raised 20 cycles after start).
module tb_sect409k1_pt_mul_host;

  localparam int W  = 32;
  localparam int NW = 13;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clr;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic         busy;
  logic         err;
  logic         pm_clr;
  logic         pm_start;
  logic [408:0] pm_d;
  logic         pm_done;
  logic [408:0] pm_x;
  logic [408:0] pm_y;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sect409k1_pt_mul_host #(.W(W), .NW(NW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .err(err), .pm_clr(pm_clr), .pm_start(pm_start), .pm_d(pm_d),
    .pm_done(pm_done), .pm_x(pm_x), .pm_y(pm_y)
  );

  // Core stub: ignores clr, so a job abandoned by clr still sees done arrive later.
  int st_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pm_done <= 1'b0;
      st_cnt  <= 0;
      pm_x    <= '0;
      pm_y    <= '0;
    end else if (pm_start) begin
      pm_done <= 1'b0;
      st_cnt  <= 20;
      pm_x    <= pm_d;
      pm_y    <= ~pm_d;
    end else if (st_cnt > 0) begin
      st_cnt <= st_cnt - 1;
      if (st_cnt == 1) pm_done <= 1'b1;
    end
  end

  typedef struct packed {
    logic [415:0] scal;
    logic [31:0]  d0;
    logic [24:0]  dtop;
    logic [31:0]  x0;
    logic [31:0]  x12;
    logic [31:0]  y0;
    logic [31:0]  y12;
    logic         stall;
  } vec_t;

  vec_t        vecs[4];
  logic [31:0] got_w[2*NW];

  task automatic chk(input string nm, input logic [408:0] act, input logic [408:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference result word k: x = d, y = ~d, each zero-padded to 416 bits.
  function automatic logic [31:0] model_word(input logic [415:0] s, input int k);
    logic [415:0] x, y;
    x = {7'b0, s[408:0]};
    y = {7'b0, ~s[408:0]};
    if (k < NW) return x[k*W +: W];
    return y[(k-NW)*W +: W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_phase(input logic [415:0] s, input string tag);
    for (int i = 0; i < NW; i++) begin
      in_valid = 1'b1;
      in_data  = s[i*W +: W];
      chk({tag, " in_ready"}, {408'b0, in_ready}, 409'd1);
      tick();
    end
    in_valid = 1'b0;
    in_data  = '0;
    chk({tag, " start_pulse"}, {408'b0, pm_start}, 409'd1);
    chk({tag, " pm_d"}, pm_d, s[408:0]);
    tick();
    chk({tag, " start_width"}, {407'b0, pm_start, busy}, 409'd1);
  endtask

  task automatic wait_phase(input bit inject, input string tag);
    bit seen;
    int extra;
    seen  = 1'b0;
    extra = 0;
    for (int k = 0; k < 100; k++) begin
      if (inject && k == 3) begin
        in_valid = 1'b1;
        in_data  = 32'hBAD0BAD0;
      end
      tick();
      if (inject && k == 3) begin
        in_valid = 1'b0;
        chk({tag, " err_set"}, {408'b0, err}, 409'd1);
      end
      if (pm_start) extra++;
      if (pm_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s done_timeout: got no done want done within 100 cycles", tag);
    end else begin
      chk({tag, " no_restart"}, 409'(extra), 409'd0);
      tick();
      chk({tag, " lat1_invalid"}, {408'b0, out_valid}, 409'd0);
      tick();
      chk({tag, " lat2_valid"}, {408'b0, out_valid}, 409'd1);
    end
  endtask

  task automatic unload_phase(input logic [415:0] s, input bit stall, input string tag);
    int got, c;
    logic [31:0] prev;
    bit prev_stall;
    got = 0;
    c = 0;
    prev = '0;
    prev_stall = 1'b0;
    while (got < 2*NW && c < 300) begin
      out_ready = stall ? ((c % 4) == 0 || (c % 4) == 3) : 1'b1;
      if (!out_valid) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s out_valid_drop: got 0 want 1 at word %0d", tag, got);
        break;
      end
      if (prev_stall) chk({tag, " stall_stable"}, {377'b0, out_data}, {377'b0, prev});
      chk({tag, " out_word"}, {377'b0, out_data}, {377'b0, model_word(s, got)});
      prev = out_data;
      prev_stall = !out_ready;
      if (out_ready) begin
        got_w[got] = out_data;
        got++;
      end
      tick();
      c++;
    end
    out_ready = 1'b0;
    chk({tag, " word_count"}, 409'(got), 409'(2*NW));
    chk({tag, " post_state"}, {406'b0, out_valid, busy, in_ready}, 409'b001);
  endtask

  task automatic run_job(input vec_t v, input bit inject, input string tag);
    load_phase(v.scal, tag);
    chk({tag, " pm_d_lo"}, {377'b0, pm_d[31:0]}, {377'b0, v.d0});
    chk({tag, " pm_d_top"}, {384'b0, pm_d[408:384]}, {384'b0, v.dtop});
    wait_phase(inject, tag);
    unload_phase(v.scal, v.stall, tag);
    chk({tag, " x0"},  {377'b0, got_w[0]},      {377'b0, v.x0});
    chk({tag, " x12"}, {377'b0, got_w[NW-1]},   {377'b0, v.x12});
    chk({tag, " y0"},  {377'b0, got_w[NW]},     {377'b0, v.y0});
    chk({tag, " y12"}, {377'b0, got_w[2*NW-1]}, {377'b0, v.y12});
  endtask

  initial begin
    int ov_seen;
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    vecs[0] = '{scal: 416'h1, d0: 32'h1, dtop: 25'h0, x0: 32'h1, x12: 32'h0,
                y0: 32'hFFFFFFFE, y12: 32'h01FFFFFF, stall: 1'b0};
    vecs[1] = '{scal: {32'hFFFFFFFF, 384'h0}, d0: 32'h0, dtop: 25'h1FFFFFF, x0: 32'h0,
                x12: 32'h01FFFFFF, y0: 32'hFFFFFFFF, y12: 32'h0, stall: 1'b0};
    vecs[2] = '{scal: {13{32'hA5A5A5A5}}, d0: 32'hA5A5A5A5, dtop: 25'h1A5A5A5,
                x0: 32'hA5A5A5A5, x12: 32'h01A5A5A5, y0: 32'h5A5A5A5A,
                y12: 32'h005A5A5A, stall: 1'b1};
    vecs[3] = '{scal: 416'h5, d0: 32'h5, dtop: 25'h0, x0: 32'h5, x12: 32'h0,
                y0: 32'hFFFFFFFA, y12: 32'h01FFFFFF, stall: 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", {408'b0, in_ready}, 409'd0);
    chk("reset_ctrl", {404'b0, out_valid, busy, err, pm_start, pm_clr}, 409'd0);
    chk("reset_out_data", {377'b0, out_data}, 409'd0);
    chk("reset_pm_d", pm_d, 409'd0);
    rst_n = 1'b1;
    tick();
    chk("post_reset_in_ready", {408'b0, in_ready}, 409'd1);

    for (int i = 0; i < 3; i++) run_job(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // Stray word during WAIT: flagged, then the job still completes.
    run_job(vecs[3], 1'b1, "inject");
    chk("err_sticky", {408'b0, err}, 409'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_err", {408'b0, err}, 409'd0);
    chk("clr_pm_clr", {408'b0, pm_clr}, 409'd0);

    // clr in WAIT abandons the job; the late done must not produce output.
    load_phase(vecs[0].scal, "abandon");
    repeat (5) tick();
    clr = 1'b1;
    #1;
    chk("pm_clr_follows", {408'b0, pm_clr}, 409'd1);
    tick();
    clr = 1'b0;
    chk("abandon_idle", {407'b0, busy, out_valid}, 409'd0);
    ov_seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (out_valid) ov_seen++;
    end
    chk("abandon_no_output", 409'(ov_seen), 409'd0);
    chk("abandon_late_done", {408'b0, pm_done}, 409'd1);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    chk("clr_discard_err", {408'b0, err}, 409'd0);
    run_job(vecs[3], 1'b0, "after_clr");

    // Asynchronous reset in the middle of loading.
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h11111111 * (i + 1);
      tick();
    end
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", {403'b0, in_ready, out_valid, busy, err, pm_start, pm_clr}, 409'd0);
    chk("midrst_out_data", {377'b0, out_data}, 409'd0);
    chk("midrst_pm_d", pm_d, 409'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_release", {408'b0, in_ready}, 409'd1);
    run_job(vecs[1], 1'b0, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
